sync_fifo_param: RTL

Parametrised single-clock FIFO for the image-filter datapath (line buffers, window generators, pixel re-timing), generalising the fixed 2048x16 FIFO to any width and power-of-two depth. Adds a standard/first-word-fall-through read mode, an exact water-level output, parameter-set almost thresholds, and optional sticky overflow/underflow flags. Storage is inferred RAM behind a registered read port, so the block maps onto device block RAM.

---
 rtl/sync_fifo_pkg.sv | 21 ++
 rtl/sync_fifo_param_ram.sv | 29 ++
 rtl/sync_fifo_param.sv | 119 +++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO.
// Level/pointer width helper, widest pointer type, flag reset values.
package sync_fifo_pkg;

  localparam int MAX_DEPTH_WIDTH = 16;

  // Widest wrap-bit pointer the block supports; instances size theirs with ptr_width().
  typedef logic [MAX_DEPTH_WIDTH:0] ptr_t;

  localparam logic RST_RD_EMPTY = 1'b1;
  localparam logic RST_ERR_FLAG = 1'b0;

  function automatic int level_width(input int depth_width);
    return depth_width + 1;
  endfunction

  function automatic int ptr_width(input int depth_width);
    return depth_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// Simple dual-port RAM, 2^ADDR_WIDTH x DATA_WIDTH, synchronous write, registered read.
// Latency: read data valid one cycle after rd_en; output register holds when rd_en is low.
// Backpressure: none, the caller guarantees address legality.
module sync_fifo_param_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO, standard or FWFT read, exact level, optional sticky errors (SYNC_FIFO_PARAM_ERR_FLAG_EN).
// Latency: standard 1 cycle rd_en->rd_data; FWFT word visible 2 edges after write into empty FIFO.
// Backpressure: writes dropped while wr_full, reads dropped while rd_empty; 1 write + 1 read per cycle.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int DEPTH_WIDTH      = 11,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int LW = level_width(DEPTH_WIDTH);
  localparam int PW = ptr_width(DEPTH_WIDTH);
  localparam logic [LW-1:0] AF_LVL = LW'(ALMOST_FULL_NUM);
  localparam logic [LW-1:0] AE_LVL = LW'(ALMOST_EMPTY_NUM);
  localparam bit FW = (FWFT != 0);

  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level;
  logic                   ptr_empty, wr_acc, rd_acc;
  logic                   stage_vld, stage_vld_nxt, q_vld;
  logic                   ram_rd_en;
  logic [DEPTH_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0]  ram_q;

  assign ptr_empty = (wr_ptr == rd_ptr);
  assign wr_full   = (wr_ptr[DEPTH_WIDTH] != rd_ptr[DEPTH_WIDTH]) &&
                     (wr_ptr[DEPTH_WIDTH-1:0] == rd_ptr[DEPTH_WIDTH-1:0]);
  assign rd_empty  = FW ? !stage_vld : ptr_empty;
  assign wr_acc    = wr_en && !wr_full;
  assign rd_acc    = rd_en && !rd_empty;

  // In FWFT mode rd_ptr is the logical head and the RAM read register is the output stage:
  // a pop refetches head+1 when more words remain, an empty stage fetches the head.
  always_comb begin
    ram_rd_en     = rd_acc;
    ram_rd_addr   = rd_ptr[DEPTH_WIDTH-1:0];
    stage_vld_nxt = stage_vld;
    if (FW) begin
      ram_rd_en = 1'b0;
      if (rd_acc) begin
        ram_rd_en     = (level > LW'(1));
        ram_rd_addr   = rd_ptr[DEPTH_WIDTH-1:0] + DEPTH_WIDTH'(1);
        stage_vld_nxt = (level > LW'(1));
      end else if (!stage_vld && !ptr_empty) begin
        ram_rd_en     = 1'b1;
        stage_vld_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      stage_vld <= ~RST_RD_EMPTY;
      q_vld     <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      if (wr_acc && !rd_acc)      level <= level + LW'(1);
      else if (rd_acc && !wr_acc) level <= level - LW'(1);
      stage_vld <= stage_vld_nxt;
      if (ram_rd_en) q_vld <= 1'b1;
    end
  end

  // RAM output register is not reset; mask it until a read has loaded it since reset.
  assign rd_data      = q_vld ? ram_q : '0;
  assign water_level  = level;
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

`ifdef SYNC_FIFO_PARAM_ERR_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= RST_ERR_FLAG;
      underflow <= RST_ERR_FLAG;
    end else begin
      if (wr_en && wr_full)  overflow  <= 1'b1;
      if (rd_en && rd_empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  sync_fifo_param_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[DEPTH_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_q)
  );

endmodule
